// File: rtl/cordic_rotation_core.sv
// Iterative rotation-mode CORDIC (cos/sin of a Q2.14 angle), one micro-rotation per clock,
// built on three ripple-carry add/sub lanes. Optional input clamping: `define CORDIC_CLAMP_EN.

module cordic_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             en,
    output logic [WIDTH-1:0] sum
);
    logic [WIDTH-1:0] raw;

    // op=1 subtracts: a + ~b + 1, with the +1 entering as the carry-in of bit 0.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic c_in;
            logic b_eff;
            assign b_eff = b[gi] ^ op;
            if (gi == 0) begin : g_cin0
                assign c_in = op;
            end else begin : g_cin
                assign c_in = g_bit[gi-1].g_carry.c_out;
            end
            assign raw[gi] = a[gi] ^ b_eff ^ c_in;
            if (gi < WIDTH - 1) begin : g_carry
                logic c_out;
                assign c_out = (a[gi] & b_eff) | (c_in & (a[gi] ^ b_eff));
            end
        end
    endgenerate

    assign sum = en ? raw : '0;
endmodule

module cordic_rotation_core #(
    parameter int BITWIDTH   = 16,
    parameter int ITERATIONS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] angle_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] cos_out,
    output logic [BITWIDTH-1:0] sin_out,
    output logic                busy,
    output logic                range_err
);
    generate
        if (BITWIDTH != 16) begin : g_bad_width
            $error("cordic_rotation_core: BITWIDTH must be 16 (arctan table is 16-bit)");
        end
        if (ITERATIONS < 1 || ITERATIONS > 16) begin : g_bad_iter
            $error("cordic_rotation_core: ITERATIONS must be in 1..16");
        end
    endgenerate

    localparam int CW = (ITERATIONS > 2) ? $clog2(ITERATIONS) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERATIONS - 1);
    localparam logic [BITWIDTH-1:0] K_INIT = BITWIDTH'(9949);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]          state_reg;
    logic [BITWIDTH-1:0] x_reg, y_reg, z_reg;
    logic [CW-1:0]       iter_reg;
    logic [BITWIDTH-1:0] cos_reg, sin_reg;
    logic [BITWIDTH-1:0] angle_load;

    function automatic logic [15:0] atan_lookup(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lookup = 16'd12868;
            4'd1:    atan_lookup = 16'd7596;
            4'd2:    atan_lookup = 16'd4014;
            4'd3:    atan_lookup = 16'd2037;
            4'd4:    atan_lookup = 16'd1023;
            4'd5:    atan_lookup = 16'd512;
            4'd6:    atan_lookup = 16'd256;
            4'd7:    atan_lookup = 16'd128;
            4'd8:    atan_lookup = 16'd64;
            4'd9:    atan_lookup = 16'd32;
            4'd10:   atan_lookup = 16'd16;
            4'd11:   atan_lookup = 16'd8;
            4'd12:   atan_lookup = 16'd4;
            4'd13:   atan_lookup = 16'd2;
            4'd14:   atan_lookup = 16'd1;
            default: atan_lookup = 16'd0;
        endcase
    endfunction

    logic                z_neg;
    logic [BITWIDTH-1:0] x_shift, y_shift, atan_val;
    logic [BITWIDTH-1:0] x_sum, y_sum, z_sum;

    assign z_neg    = z_reg[BITWIDTH-1];
    assign x_shift  = $signed(x_reg) >>> iter_reg;
    assign y_shift  = $signed(y_reg) >>> iter_reg;
    assign atan_val = atan_lookup(4'(iter_reg));

    // Direction d=+1 (z>=0): x subtracts, y adds, z subtracts; d=-1 flips each lane.
    cordic_addsub #(.WIDTH(BITWIDTH)) u_x_lane (
        .a(x_reg), .b(y_shift), .op(~z_neg), .en(1'b1), .sum(x_sum)
    );
    cordic_addsub #(.WIDTH(BITWIDTH)) u_y_lane (
        .a(y_reg), .b(x_shift), .op(z_neg), .en(1'b1), .sum(y_sum)
    );
    cordic_addsub #(.WIDTH(BITWIDTH)) u_z_lane (
        .a(z_reg), .b(atan_val), .op(~z_neg), .en(1'b1), .sum(z_sum)
    );

`ifdef CORDIC_CLAMP_EN
    localparam logic signed [BITWIDTH-1:0] ANGLE_MAX = 16'sd25736;
    localparam logic signed [BITWIDTH-1:0] ANGLE_MIN = -16'sd25736;
    logic clamp_hi, clamp_lo;
    logic range_err_reg;

    assign clamp_hi   = $signed(angle_in) > ANGLE_MAX;
    assign clamp_lo   = $signed(angle_in) < ANGLE_MIN;
    assign angle_load = clamp_hi ? ANGLE_MAX : (clamp_lo ? ANGLE_MIN : angle_in);
    assign range_err  = range_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err_reg <= 1'b0;
        end else if (state_reg == IDLE && in_valid) begin
            range_err_reg <= clamp_hi | clamp_lo;
        end
    end
`else
    assign angle_load = angle_in;
    assign range_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter_reg  <= '0;
            cos_reg   <= '0;
            sin_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= K_INIT;
                        y_reg     <= '0;
                        z_reg     <= angle_load;
                        iter_reg  <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    x_reg    <= x_sum;
                    y_reg    <= y_sum;
                    z_reg    <= z_sum;
                    iter_reg <= iter_reg + 1'b1;
                    if (iter_reg == LAST_ITER) begin
                        cos_reg   <= x_sum;
                        sin_reg   <= y_sum;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == RUN);
    assign out_valid = (state_reg == HOLD);
    assign cos_out   = cos_reg;
    assign sin_out   = sin_reg;
endmodule

// File: tb/tb_cordic_rotation_core.sv
// Scoreboard bench for cordic_rotation_core: random and directed angles checked against
// an integer CORDIC reference plus trig tolerances, with backpressure and mid-run reset.
module tb_cordic_rotation_core;
    localparam int ITER = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] angle_in = '0;
    logic        in_ready, out_valid, busy, range_err;
    logic [15:0] cos_out, sin_out;

    cordic_rotation_core #(.BITWIDTH(16), .ITERATIONS(ITER)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .angle_in(angle_in), .out_valid(out_valid), .out_ready(out_ready),
        .cos_out(cos_out), .sin_out(sin_out), .busy(busy), .range_err(range_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int c;
        int s;
        bit chk;
        bit rerr;
        int acc;
        bit has_ref;
        int rc;
        int rs;
    } exp_t;
    exp_t sbq[$];
    bit rand_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        tests++;
        if (act < exp - tol || act > exp + tol) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Plain algorithmic CORDIC: x,y,z rotate with wraparound at 16 bits.
    function automatic void cordic_model(input int ang, output int c, output int s);
        int atan_tab[16] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0};
        shortint x, y, z, xn, yn;
        x = 16'sd9949;
        y = 16'sd0;
        z = shortint'(ang);
        for (int k = 0; k < ITER; k++) begin
            if (z >= 0) begin
                xn = shortint'(int'(x) - int'(y >>> k));
                yn = shortint'(int'(y) + int'(x >>> k));
                z  = shortint'(int'(z) - atan_tab[k]);
            end else begin
                xn = shortint'(int'(x) + int'(y >>> k));
                yn = shortint'(int'(y) - int'(x >>> k));
                z  = shortint'(int'(z) + atan_tab[k]);
            end
            x = xn;
            y = yn;
        end
        c = int'(x);
        s = int'(y);
    endfunction

    task automatic send(input int ang, input bit has_ref, input int rc, input int rs);
        exp_t e;
        bit ok = 1'b0;
        int za = ang;
        e.rerr = 1'b0;
        e.chk = 1'b1;
`ifdef CORDIC_CLAMP_EN
        if (ang > 25736) begin za = 25736; e.rerr = 1'b1; end
        if (ang < -25736) begin za = -25736; e.rerr = 1'b1; end
`else
        if (ang > 25736 || ang < -25736) e.chk = 1'b0;
`endif
        cordic_model(za, e.c, e.s);
        e.has_ref = has_ref;
        e.rc = rc;
        e.rs = rs;
        @(posedge clk); #1;
        in_valid = 1'b1;
        angle_in = 16'(ang);
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cyc + 1;
                sbq.push_back(e);
                ok = 1'b1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    // Monitor: latency on rising out_valid, data on handshake, stability while held.
    initial begin
        bit hold_prev = 1'b0;
        bit ov_prev = 1'b0;
        int pc = 0, ps = 0, pr = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (hold_prev) begin
                check("hold_cos_stable", int'($signed(cos_out)), pc);
                check("hold_sin_stable", int'($signed(sin_out)), ps);
                check("hold_rerr_stable", int'(range_err), pr);
            end
            if (out_valid && !ov_prev && sbq.size() > 0)
                check("latency", cyc, sbq[0].acc + ITER);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    $display("[TB] result cos=%0d sin=%0d range_err=%0d | model cos=%0d sin=%0d rerr=%0d",
                             $signed(cos_out), $signed(sin_out), range_err, e.c, e.s, e.rerr);
                    if (e.chk) begin
                        check("cos_exact", int'($signed(cos_out)), e.c);
                        check("sin_exact", int'($signed(sin_out)), e.s);
                    end
                    if (e.has_ref) begin
                        check_tol("cos_ref", int'($signed(cos_out)), e.rc, 4);
                        check_tol("sin_ref", int'($signed(sin_out)), e.rs, 4);
                    end
                    check("range_err", int'(range_err), int'(e.rerr));
                end
            end
            hold_prev = out_valid && !out_ready;
            ov_prev = out_valid;
            pc = int'($signed(cos_out));
            ps = int'($signed(sin_out));
            pr = int'(range_err);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_drain();
        for (int t = 0; t < 2000 && sbq.size() > 0; t++) @(negedge clk);
        check("queue_drained", sbq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_range_err"}, int'(range_err), 0);
        check({tag, "_cos"}, int'(cos_out), 0);
        check({tag, "_sin"}, int'(sin_out), 0);
    endtask

    initial begin
        int seen;
        bool_wait: begin end
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed angles from the trig identities.
        send(0, 1'b1, 16384, 0);
        check("busy_in_run", int'(busy), 1);
        check("in_ready_in_run", int'(in_ready), 0);
        send(12868, 1'b1, 11585, 11585);
        send(-25736, 1'b1, 0, -16384);
        send(25736, 1'b1, 0, 16384);
        wait_drain();

        // Backpressure with ignored in_valid pulses in RUN and HOLD.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(12868, 1'b1, 11585, 11585);
        in_valid = 1'b1;
        angle_in = 16'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("bp_out_valid_seen", seen, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid = (k == 2);
            angle_in = 16'd2000;
            @(negedge clk);
            check("bp_in_ready_low", int'(in_ready), 0);
            check("bp_out_valid_high", int'(out_valid), 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_release_out_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_pulses_ignored", sbq.size(), 0);

        // Out-of-range angles.
        send(30000, 1'b0, 0, 0);
        wait_drain();
`ifdef CORDIC_CLAMP_EN
        send(30000, 1'b1, 0, 16384);
        send(-30000, 1'b1, 0, -16384);
        send(1000, 1'b0, 0, 0);
`else
        send(-30000, 1'b0, 0, 0);
`endif
        wait_drain();

        // Randomised angles with random consumer backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 30; n++)
            send(int'($urandom_range(0, 51472)) - 25736, 1'b0, 0, 0);
        wait_drain();
        rand_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Asynchronous reset in the middle of iteration 7.
        send(8000, 1'b0, 0, 0);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int t = 0; t < ITER + 6; t++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_out_valid", seen, 0);
        send(0, 1'b1, 16384, 0);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cordic_rotation_core.md
Name: cordic_rotation_core

Overview:
- Iterative rotation-mode CORDIC engine. It computes cos/sin of a signed angle, one micro-rotation per clock.
- It is the sequential stage directly upstream of the ripple-carry add/sub units. Each cycle it drives their operands and `op` (direction) lines, then registers their sums.
- It instantiates three add/sub units for the X, Y and Z lanes, with `en` tied high.
- Valid/ready handshakes sit on both sides.

Parameters:
- BITWIDTH, 16, datapath width. Only 16 is supported; any other value is an elaboration error, because the arctan ROM is 16-bit.
- ITERATIONS, 16, number of micro-rotations, range 1..16.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  angle_in is valid.
- in_ready  output  1  core idle; accepts a new angle.
- angle_in  input  BITWIDTH  signed angle, Q2.14 radians, legal range -25736..25736 (±pi/2).
- out_valid  output  1  cos_out/sin_out valid.
- out_ready  input  1  consumer accepts the result.
- cos_out  output  BITWIDTH  signed cosine, Q2.14.
- sin_out  output  BITWIDTH  signed sine, Q2.14.
- busy  output  1  high in RUN.
- range_err  output  1  angle was clamped (see Optional Feature); 0 when the feature is compiled out.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, range_err=0, cos_out=0, sin_out=0, x/y/z=0, iteration counter=0.
- Reset is asynchronous and may assert mid-operation. It aborts any computation; no out_valid is produced for an aborted angle.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load x=9949 (K≈0.607253 in Q2.14), y=0, z=angle_in, i=0; go to RUN.
- RUN (busy=1, in_ready=0): one iteration per cycle. With d=+1 if z>=0, else d=-1:
  - x <= x - d*(y>>>i)
  - y <= y + d*(x>>>i)
  - z <= z - d*atan_rom[i]
  - i <= i+1
- Add/sub op assignment, with op=1 meaning subtract:
  - X lane: op = ~z[15].
  - Y lane: op = z[15].
  - Z lane: op = ~z[15].
- Shifts are arithmetic, sign-extending. Carry-out is ignored. Results wrap modulo 2^16; there is no saturation.
- atan_rom[0..15] = 12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0.
- The iteration counter width is max(1, clog2(ITERATIONS)).
- On the edge completing iteration ITERATIONS-1:
  - cos_out <= new x, sin_out <= new y.
  - out_valid <= 1; go to HOLD.
- Latency: out_valid rises exactly ITERATIONS cycles after the accepting edge.
- HOLD:
  - out_valid=1; cos_out, sin_out and range_err are held stable.
  - in_valid is ignored; in_ready=0.
  - On out_ready=1: out_valid <= 0 and go to IDLE. A new angle can be accepted the cycle after return, giving a throughput of ITERATIONS+2 cycles per result with out_ready tied high.
- in_valid during RUN or HOLD is ignored; it is not queued.
- out_ready asserted outside HOLD has no effect.
- cos_out and sin_out keep the last result after the out_valid handshake, until the next result is written.
- K is fixed at 9949 for any ITERATIONS. Gain error for ITERATIONS<16 is accepted.

Optional Feature:
- Macro: CORDIC_CLAMP_EN.
- Defined: at acceptance, angle_in >25736 loads z=25736, and angle_in <-25736 loads z=-25736. range_err is set to 1 for that result and held through HOLD; it clears on the next acceptance of an in-range angle.
- Undefined: angle_in is loaded unmodified, the result for out-of-range angles is unspecified, and range_err is constant 0.

Test Plan:
- After reset: in_ready=1, out_valid=0, busy=0, cos_out=sin_out=0. angle_in=0 with ITERATIONS=16 -> out_valid exactly 16 cycles after acceptance; cos_out=16384±4, sin_out=0±4.
- angle_in=12868 (pi/4) -> cos_out=11585±4, sin_out=11585±4.
- angle_in=-25736 (-pi/2) -> cos_out=0±4, sin_out=-16384±4.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 pulsed during RUN and HOLD -> outputs stable, in_ready=0, pulses ignored. Releasing out_ready -> out_valid drops next edge, in_ready=1.
- rst_n low at iteration 7, asynchronously mid-cycle -> all outputs return to reset values immediately. A subsequent angle 0 gives the correct result and no stale out_valid.
- With CORDIC_CLAMP_EN: angle_in=30000 -> range_err=1, result equals that for 25736 (cos 0±4, sin 16384±4). Without it -> range_err=0 throughout.
